// File: rtl/aes_avl_pkg.sv
// rtl/aes_avl_pkg.sv - shared state encoding and register map of the AES slave register file
package aes_avl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_KEY,
        S_WR_MSG,
        S_WR_START,
        S_POLL,
        S_GAP,
        S_RD_OUT,
        S_CLR_START,
        S_FINISH
    } state_t;

    localparam logic [3:0]  ADDR_KEY0  = 4'd0;
    localparam logic [3:0]  ADDR_MSG0  = 4'd4;
    localparam logic [3:0]  ADDR_DEC0  = 4'd8;
    localparam logic [3:0]  ADDR_START = 4'd14;
    localparam logic [3:0]  ADDR_DONE  = 4'd15;
    localparam logic [31:0] START_VAL  = 32'h1;

    // Word 0 is the most significant 32 bits of the 128-bit value.
    function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] idx);
        return v[{~idx, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/avalon_aes_master.sv
// rtl/avalon_aes_master.sv - Avalon-MM master sequencing one AES decryption through the slave register file
module avalon_aes_master
    import aes_avl_pkg::*;
#(
    parameter int POLL_GAP  = 3,
    parameter int MAX_POLLS = 1024
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         REQ_START,
    input  logic [127:0] REQ_KEY,
    input  logic [127:0] REQ_MSG,
    output logic         REQ_BUSY,
    output logic         REQ_DONE,
    output logic         REQ_ERROR,
    output logic [127:0] REQ_RESULT,
    output logic         AVM_READ,
    output logic         AVM_WRITE,
    output logic         AVM_CS,
    output logic [3:0]   AVM_BYTE_EN,
    output logic [3:0]   AVM_ADDR,
    output logic [31:0]  AVM_WRITEDATA,
    input  logic [31:0]  AVM_READDATA
);

    localparam int GW = $clog2(POLL_GAP + 2);
    localparam int PW = $clog2(MAX_POLLS + 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP > 0 ? POLL_GAP - 1 : 0);
    localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS - 1);

    state_t        state, state_nxt;
    logic [1:0]    wcnt, wcnt_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic [PW-1:0] poll_cnt, poll_nxt;
    logic          err_flag, err_nxt;
    logic          accept;
    logic [127:0]  key_q, msg_q, shadow, key_src;
    logic          rd_nxt, wr_nxt;
    logic [3:0]    addr_nxt;
    logic [31:0]   wdata_nxt;

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        gap_nxt   = gap_cnt;
        poll_nxt  = poll_cnt;
        err_nxt   = err_flag;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (REQ_START) begin
                    accept    = 1'b1;
                    state_nxt = S_WR_KEY;
                    wcnt_nxt  = '0;
                    err_nxt   = 1'b0;
                end
            end
            S_WR_KEY: begin
                wcnt_nxt = wcnt + 2'd1;
                if (wcnt == 2'd3) state_nxt = S_WR_MSG;
            end
            S_WR_MSG: begin
                wcnt_nxt = wcnt + 2'd1;
                if (wcnt == 2'd3) state_nxt = S_WR_START;
            end
            S_WR_START: begin
                state_nxt = S_POLL;
                poll_nxt  = '0;
            end
            S_POLL: begin
                poll_nxt = poll_cnt + PW'(1);
                gap_nxt  = '0;
                if (AVM_READDATA[0]) begin
                    state_nxt = S_RD_OUT;
                    wcnt_nxt  = '0;
                end else if (poll_cnt == POLL_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_CLR_START;
                end else if (POLL_GAP == 0) begin
                    state_nxt = S_POLL;
                end else begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                gap_nxt = gap_cnt + GW'(1);
                if (gap_cnt == GAP_LAST) state_nxt = S_POLL;
            end
            S_RD_OUT: begin
                wcnt_nxt = wcnt + 2'd1;
                if (wcnt == 2'd3) state_nxt = S_CLR_START;
            end
            S_CLR_START: state_nxt = S_FINISH;
            S_FINISH:    state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase

        // Bus outputs are registered, so decode them from the state being entered.
        key_src   = accept ? REQ_KEY : key_q;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        addr_nxt  = '0;
        wdata_nxt = '0;
        case (state_nxt)
            S_WR_KEY: begin
                wr_nxt    = 1'b1;
                addr_nxt  = ADDR_KEY0 + {2'b00, wcnt_nxt};
                wdata_nxt = word_sel(key_src, wcnt_nxt);
            end
            S_WR_MSG: begin
                wr_nxt    = 1'b1;
                addr_nxt  = ADDR_MSG0 + {2'b00, wcnt_nxt};
                wdata_nxt = word_sel(msg_q, wcnt_nxt);
            end
            S_WR_START: begin
                wr_nxt    = 1'b1;
                addr_nxt  = ADDR_START;
                wdata_nxt = START_VAL;
            end
            S_POLL: begin
                rd_nxt   = 1'b1;
                addr_nxt = ADDR_DONE;
            end
            S_RD_OUT: begin
                rd_nxt   = 1'b1;
                addr_nxt = ADDR_DEC0 + {2'b00, wcnt_nxt};
            end
            S_CLR_START: begin
                wr_nxt   = 1'b1;
                addr_nxt = ADDR_START;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= S_IDLE;
            wcnt          <= '0;
            gap_cnt       <= '0;
            poll_cnt      <= '0;
            err_flag      <= 1'b0;
            key_q         <= '0;
            msg_q         <= '0;
            shadow        <= '0;
            REQ_BUSY      <= 1'b0;
            REQ_DONE      <= 1'b0;
            REQ_ERROR     <= 1'b0;
            REQ_RESULT    <= '0;
            AVM_READ      <= 1'b0;
            AVM_WRITE     <= 1'b0;
            AVM_CS        <= 1'b0;
            AVM_BYTE_EN   <= 4'h0;
            AVM_ADDR      <= '0;
            AVM_WRITEDATA <= '0;
        end else begin
            state         <= state_nxt;
            wcnt          <= wcnt_nxt;
            gap_cnt       <= gap_nxt;
            poll_cnt      <= poll_nxt;
            err_flag      <= err_nxt;
            AVM_READ      <= rd_nxt;
            AVM_WRITE     <= wr_nxt;
            AVM_CS        <= rd_nxt | wr_nxt;
            AVM_BYTE_EN   <= (rd_nxt | wr_nxt) ? 4'hF : 4'h0;
            AVM_ADDR      <= addr_nxt;
            AVM_WRITEDATA <= wdata_nxt;
            if (accept) begin
                key_q <= REQ_KEY;
                msg_q <= REQ_MSG;
            end
            if (state == S_RD_OUT) shadow[{~wcnt, 5'b0} +: 32] <= AVM_READDATA;
            REQ_BUSY <= (state_nxt != S_IDLE) && (state_nxt != S_FINISH);
            REQ_DONE <= (state_nxt == S_FINISH);
            if (accept) REQ_ERROR <= 1'b0;
            else if (state_nxt == S_FINISH) REQ_ERROR <= err_nxt;
            if (state_nxt == S_FINISH && !err_nxt) REQ_RESULT <= shadow;
        end
    end

endmodule
